dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the core datapath (port 0: load/store from the execute stage) and a debug/loader requester (port 1: program/data preload and memory inspection). It grants one access per cycle and drives the memory's read/write strobes, address and write data. It registers read data back to the winning port and raises a stall toward the core whenever the core's request is not granted. An optional lock lets a port perform uninterrupted multi-access sequences, bounded by a timeout counter.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (port 0) vs debug/loader (port 1), one access per cycle.
// Define DMEM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int DATA_W     = 64,
  parameter int DM_ADDRESS = 9,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic                  c0_lock,
  input  logic [DM_ADDRESS-1:0] c0_addr,
  input  logic [DATA_W-1:0]     c0_wdata,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic                  c1_lock,
  input  logic [DM_ADDRESS-1:0] c1_addr,
  input  logic [DATA_W-1:0]     c1_wdata,
  output logic                  c0_gnt,
  output logic                  c1_gnt,
  output logic                  c0_rvalid,
  output logic                  c1_rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  core_stall,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

`ifdef DMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e            r_owner;
  logic              r_last_gnt;
  logic              r_to_pend;   // a lock just timed out: the waiting port wins the next conflict
  logic [CNT_W-1:0]  r_lock_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid0;
  logic              r_rvalid1;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_win;
  logic              w_we;
  logic              w_lock;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt_inc;

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      case (r_owner)
        OWN_P0: w_gnt0 = c0_req;
        OWN_P1: w_gnt1 = c1_req;
        default: begin
          if (c0_req && c1_req) begin
            if ((RR_EN || r_to_pend) && !r_last_gnt) w_gnt1 = 1'b1;
            else                                       w_gnt0 = 1'b1;
          end else begin
            w_gnt0 = c0_req;
            w_gnt1 = c1_req;
          end
        end
      endcase
    end
  end

  assign w_any     = w_gnt0 | w_gnt1;
  assign w_win     = w_gnt1;
  assign w_we      = w_win ? c1_we   : c0_we;
  assign w_lock    = w_win ? c1_lock : c0_lock;
  assign w_cnt_inc = r_lock_cnt + 1'b1;
  assign w_timeout = w_any & w_lock & (w_cnt_inc == LOCK_LIM);

  assign c0_gnt     = w_gnt0;
  assign c1_gnt     = w_gnt1;
  assign core_stall = reset & c0_req & ~w_gnt0;
  assign mem_we     = w_any & w_we;
  assign mem_re     = w_any & ~w_we;
  assign mem_addr   = w_any ? (w_win ? c1_addr  : c0_addr)  : '0;
  assign mem_wdata  = w_any ? (w_win ? c1_wdata : c0_wdata) : '0;

  assign c0_rvalid = r_rvalid0;
  assign c1_rvalid = r_rvalid1;
  assign rdata     = r_rdata;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner    <= OWN_NONE;
      r_last_gnt <= 1'b0;
      r_to_pend  <= 1'b0;
      r_lock_cnt <= '0;
      r_rdata    <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~c0_we;
      r_rvalid1 <= w_gnt1 & ~c1_we;
      if (mem_re) r_rdata <= mem_rdata;
      if (w_any) begin
        r_last_gnt <= w_win;
        r_to_pend  <= w_timeout;
        if (w_lock && !w_timeout) begin
          r_owner    <= w_win ? OWN_P1 : OWN_P0;
          r_lock_cnt <= w_cnt_inc;
        end else begin
          r_owner    <= OWN_NONE;
          r_lock_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (ownership, lock budget, shadow memory). Honours DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  localparam int DATA_W   = 64;
  localparam int AW       = 9;
  localparam int LOCK_MAX = 8;
  localparam int DEPTH    = 1 << AW;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              c0_req, c0_we, c0_lock;
  logic [AW-1:0]     c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c1_req, c1_we, c1_lock;
  logic [AW-1:0]     c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              core_stall, mem_re, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  dmem_arbiter #(.DATA_W(DATA_W), .DM_ADDRESS(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_lock(c0_lock), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_lock(c1_lock), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .rdata(rdata), .core_stall(core_stall), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 64'(i) * 64'h0101_0101_0101_0101;
  endfunction

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Memory attached to the DUT: combinational read, write at the clock edge.
  logic [DATA_W-1:0] env_mem [DEPTH];
  assign mem_rdata = env_mem[mem_addr];
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model: owner -1 = nobody, 0/1 = port; bonus = port owed the next conflict.
  int                m_owner = -1;
  int                m_cnt   = 0;
  int                m_last  = 0;
  int                m_bonus = -1;
  logic              m_rv0   = 1'b0;
  logic              m_rv1   = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [DATA_W-1:0] ref_mem [DEPTH];

  function automatic int pick(input logic r0, input logic r1);
    if (m_owner == 0) return r0 ? 0 : -1;
    if (m_owner == 1) return r1 ? 1 : -1;
    if (r0 && r1) begin
      if (m_bonus >= 0) return m_bonus;
      return RR ? 1 - m_last : 0;
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_owner = -1; m_cnt = 0; m_last = 0; m_bonus = -1;
        m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
      end else begin
        int w;
        logic we, lk;
        logic [AW-1:0] a;
        w = pick(c0_req, c1_req);
        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (w >= 0) begin
          we = (w == 1) ? c1_we   : c0_we;
          lk = (w == 1) ? c1_lock : c0_lock;
          a  = (w == 1) ? c1_addr : c0_addr;
          if (we) ref_mem[a] = (w == 1) ? c1_wdata : c0_wdata;
          else begin
            m_rdata = ref_mem[a];
            if (w == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
          end
          m_last  = w;
          m_bonus = -1;
          if (lk) begin
            m_cnt++;
            if (m_cnt == LOCK_MAX) begin
              m_owner = -1; m_cnt = 0; m_bonus = 1 - w;
            end else m_owner = w;
          end else begin
            m_owner = -1; m_cnt = 0;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    int w;
    logic e_we;
    logic [AW-1:0] e_a;
    logic [DATA_W-1:0] e_d;
    w    = reset ? pick(c0_req, c1_req) : -1;
    e_we = (w == 1) ? c1_we : c0_we;
    e_a  = (w < 0) ? '0 : ((w == 1) ? c1_addr  : c0_addr);
    e_d  = (w < 0) ? '0 : ((w == 1) ? c1_wdata : c0_wdata);
    check("c0_gnt",     c0_gnt,     w == 0);
    check("c1_gnt",     c1_gnt,     w == 1);
    check("core_stall", core_stall, reset && c0_req && w != 0);
    check("mem_re",     mem_re,     w >= 0 && !e_we);
    check("mem_we",     mem_we,     w >= 0 && e_we);
    check("mem_addr",   mem_addr,   e_a);
    check("mem_wdata",  mem_wdata,  e_d);
    check("c0_rvalid",  c0_rvalid,  m_rv0);
    check("c1_rvalid",  c1_rvalid,  m_rv1);
    check("rdata",      rdata,      m_rdata);
  end

  task automatic set_c0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
    c0_req = req; c0_we = we; c0_lock = lock; c0_addr = addr; c0_wdata = data;
  endtask

  task automatic set_c1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DATA_W-1:0] data);
    c1_req = req; c1_we = we; c1_lock = lock; c1_addr = addr; c1_wdata = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n1;
    logic g0_last, g1_last;
    reset = 1'b1;
    set_c0(1'b1, 1'b0, 1'b0, '0, '0);
    set_c1(1'b1, 1'b0, 1'b0, '0, '0);
    #1 reset = 1'b0;

    // Reset holds everything quiet even with both ports requesting.
    @(negedge clk);
    check("rst_c0_gnt", c0_gnt, 0);
    check("rst_c1_gnt", c1_gnt, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_stall",  core_stall, 0);
    check("rst_rdata",  rdata, 0);

    // First read right after release.
    next_cycle();
    reset = 1'b1;
    set_c0(1'b1, 1'b0, 1'b0, 9'h010, '0);
    set_c1(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("first_gnt",  c0_gnt, 1);
    check("first_addr", mem_addr, 9'h010);
    next_cycle();
    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("first_rvalid", c0_rvalid, 1);
    check("first_rdata",  rdata, 64'h1010_1010_1010_1010);

    // Port 1 writes, port 0 reads it back.
    next_cycle();
    set_c1(1'b1, 1'b1, 1'b0, 9'h020, 64'hDEAD_BEEF);
    @(negedge clk);
    check("wr_c1_gnt", c1_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    next_cycle();
    set_c1(1'b0, 1'b0, 1'b0, '0, '0);
    set_c0(1'b1, 1'b0, 1'b0, 9'h020, '0);
    @(negedge clk);
    check("rd_c0_gnt", c0_gnt, 1);
    next_cycle();
    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rd_rvalid", c0_rvalid, 1);
    check("rd_rdata",  rdata, 64'hDEAD_BEEF);

    // Continuous conflict for six cycles; the last grant went to port 0.
    next_cycle();
    set_c0(1'b1, 1'b0, 1'b0, 9'h030, '0);
    set_c1(1'b1, 1'b0, 1'b0, 9'h031, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("conf_c0_gnt", c0_gnt, RR ? 1'(i % 2) : 1'b1);
      check("conf_c1_gnt", c1_gnt, RR ? 1'((i + 1) % 2) : 1'b0);
      check("conf_stall",  core_stall, RR ? 1'((i + 1) % 2) : 1'b0);
      next_cycle();
    end

    // Port 1 locks for three accesses, the last two while port 0 waits.
    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    set_c1(1'b1, 1'b0, 1'b1, 9'h040, '0);
    @(negedge clk);
    check("lock_first", c1_gnt, 1);
    next_cycle();
    set_c0(1'b1, 1'b0, 1'b0, 9'h050, '0);
    for (int j = 0; j < 3; j++) begin
      set_c1(1'b1, 1'b0, 1'(j < 2), 9'h041, '0);
      @(negedge clk);
      check("lock_c1_gnt", c1_gnt, 1);
      check("lock_stall",  core_stall, 1);
      next_cycle();
    end
    set_c1(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("unlock_c0_gnt", c0_gnt, 1);
    check("unlock_stall",  core_stall, 0);

    // Lock timeout: port 1 holds lock forever, port 0 waits from the second cycle.
    next_cycle();
    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    set_c1(1'b1, 1'b0, 1'b1, 9'h060, '0);
    n1 = 0;
    g0_last = 1'b0;
    g1_last = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) set_c0(1'b1, 1'b0, 1'b0, 9'h070, '0);
      @(negedge clk);
      n1 += int'(c1_gnt);
      g0_last = c0_gnt;
      g1_last = c1_gnt;
      next_cycle();
    end
    check("timeout_c1_grants", 64'(n1), 8);
    check("timeout_c0_wins",   g0_last, 1);
    check("timeout_c1_waits",  g1_last, 0);

    // Reset during a locked read cancels rvalid and ownership.
    set_c1(1'b0, 1'b0, 1'b0, '0, '0);
    set_c0(1'b1, 1'b0, 1'b1, 9'h080, '0);
    @(negedge clk);
    check("rstlock_gnt", c0_gnt, 1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rstlock_rvalid", c0_rvalid, 0);
    check("rstlock_c0_gnt", c0_gnt, 0);
    #1;
    reset = 1'b1;
    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    set_c1(1'b1, 1'b0, 1'b0, 9'h090, '0);
    @(negedge clk);
    check("rstlock_c1_gnt", c1_gnt, 1);
    next_cycle();

    // Randomized traffic; lock density varies so timeouts and long ownership both occur.
    for (int n = 0; n < 3000; n++) begin
      int lock_pct;
      lock_pct = (n / 500) % 2 == 1 ? 85 : 25;
      set_c0($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < lock_pct, AW'($urandom_range(0, 31)),
             {$urandom, $urandom});
      set_c1($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
             $urandom_range(0, 99) < lock_pct, AW'($urandom_range(0, 31)),
             {$urandom, $urandom});
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
      next_cycle();
    end

    set_c0(1'b0, 1'b0, 1'b0, '0, '0);
    set_c1(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
